// File: rtl/text_pkg.sv
// Shared constants for the text overlay address generator.
// Glyph geometry defaults, the reset character code and the cursor blink period.
package text_pkg;

    localparam int GLYPH_W_DEF = 8;
    localparam int GLYPH_H_DEF = 16;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam int BLINK_FRAMES = 30;

endpackage

// File: rtl/text_addr_gen_if.sv
// Character write handshake between a host (master) and the text buffer (slave).
// A write transfers on any cycle where wr_valid and wr_ready are both high.
interface text_addr_gen_if #(
    parameter int IDX_W = 4
) ();

    logic             wr_valid;
    logic             wr_ready;
    logic [IDX_W-1:0] wr_index;
    logic [7:0]       wr_ascii;

    modport master (
        output wr_valid,
        output wr_index,
        output wr_ascii,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_index,
        input  wr_ascii,
        output wr_ready
    );

endinterface

// File: rtl/text_char_buf.sv
// Double-buffered character storage for the text overlay.
// Host writes land in the shadow copy; frame_start copies shadow to active so a
// frame is always rendered from a consistent string. Writes are refused in the
// frame_start cycle so the copy never races an update.
module text_char_buf
    import text_pkg::*;
#(
    parameter int NUM_CHARS = 16,
    localparam int IDX_W = $clog2(NUM_CHARS)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             frame_start,
    text_addr_gen_if.slave   wr,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [7:0]       rd_ascii
);

    logic [7:0] shadow [NUM_CHARS];
    logic [7:0] active [NUM_CHARS];

    assign wr.wr_ready = ~frame_start;

    // Shadow buffer: accept host writes; later writes to the same index win.
    // NOTE: both buffers are reset entry by entry because the blank string must be
    // visible immediately after reset, so they map to flops rather than a RAM macro.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_CHARS; i++) shadow[i] <= ASCII_SPACE;
        end else if (wr.wr_valid && wr.wr_ready) begin
            shadow[wr.wr_index] <= wr.wr_ascii;
        end
    end

    // Active buffer: snapshot the shadow copy once per frame.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_CHARS; i++) active[i] <= ASCII_SPACE;
        end else if (frame_start) begin
            for (int i = 0; i < NUM_CHARS; i++) active[i] <= shadow[i];
        end
    end

    assign rd_ascii = active[rd_idx];

endmodule

// File: rtl/text_addr_gen.sv
// Text overlay address generator: maps the current pixel to a font ROM row
// address and bit column for a string of NUM_CHARS glyphs placed at a latched
// origin. Two-stage pipeline: stage 1 decodes hit/index/row/column, stage 2
// reads the character code and forms the ROM address.
// Optional feature: define TEXT_CURSOR_EN for a blinking inverted cursor cell.
module text_addr_gen
    import text_pkg::*;
#(
    parameter int NUM_CHARS = 16,
    parameter int GLYPH_W   = GLYPH_W_DEF,
    parameter int GLYPH_H   = GLYPH_H_DEF,
    parameter int COORD_W   = 11,
    localparam int IDX_W = $clog2(NUM_CHARS),
    localparam int COL_W = $clog2(GLYPH_W),
    localparam int ROW_W = $clog2(GLYPH_H)
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_start,
    input  logic [COORD_W-1:0] origin_x,
    input  logic [COORD_W-1:0] origin_y,
    text_addr_gen_if.slave     wr,
    input  logic [9:0]         DrawX,
    input  logic [9:0]         DrawY,
`ifdef TEXT_CURSOR_EN
    input  logic               cursor_en,
    input  logic [IDX_W-1:0]   cursor_idx,
`endif
    output logic               sprite_on,
    output logic [8+ROW_W-1:0] sprite_addr,
    output logic [COL_W-1:0]   glyph_col,
    output logic               glyph_invert
);

    // Span limits expressed in the same signed width as the offsets.
    localparam logic signed [COORD_W:0] SPAN_X = (COORD_W+1)'(NUM_CHARS * GLYPH_W);
    localparam logic signed [COORD_W:0] SPAN_Y = (COORD_W+1)'(GLYPH_H);

    logic [COORD_W-1:0] ox, oy;

    // Latch the string origin once per frame so it cannot move mid-scan.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ox <= '0;
            oy <= '0;
        end else if (frame_start) begin
            ox <= origin_x;
            oy <= origin_y;
        end
    end

    // Offsets are one bit wider than the origin and signed, so a pixel left of
    // or above the origin yields a negative value instead of wrapping into range.
    logic signed [COORD_W:0] dx, dy;
    logic                    hit;

    assign dx  = signed'({{(COORD_W-9){1'b0}}, DrawX}) - signed'({1'b0, ox});
    assign dy  = signed'({{(COORD_W-9){1'b0}}, DrawY}) - signed'({1'b0, oy});
    assign hit = !dx[COORD_W] && (dx < SPAN_X) && !dy[COORD_W] && (dy < SPAN_Y);

`ifdef TEXT_CURSOR_EN
    localparam int CNT_W = $clog2(BLINK_FRAMES);

    logic             cur_en_q;
    logic [IDX_W-1:0] cur_idx_q;
    logic [CNT_W-1:0] blink_cnt;
    logic             blink_phase;

    // Cursor controls are sampled with the origin; the phase flips every
    // BLINK_FRAMES frames.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cur_en_q    <= 1'b0;
            cur_idx_q   <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_start) begin
            cur_en_q  <= cursor_en;
            cur_idx_q <= cursor_idx;
            if (blink_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end
`endif

    logic             s1_hit;
    logic [IDX_W-1:0] s1_idx;
    logic [COL_W-1:0] s1_col;
    logic [ROW_W-1:0] s1_row;
`ifdef TEXT_CURSOR_EN
    logic             s1_inv;
`endif

    // Stage 1: register the decoded cell position; a miss zeroes every field.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s1_hit <= 1'b0;
            s1_idx <= '0;
            s1_col <= '0;
            s1_row <= '0;
`ifdef TEXT_CURSOR_EN
            s1_inv <= 1'b0;
`endif
        end else begin
            s1_hit <= hit;
            s1_idx <= hit ? dx[IDX_W+COL_W-1:COL_W] : '0;
            s1_col <= hit ? dx[COL_W-1:0] : '0;
            s1_row <= hit ? dy[ROW_W-1:0] : '0;
`ifdef TEXT_CURSOR_EN
            s1_inv <= hit && cur_en_q && blink_phase
                      && (dx[IDX_W+COL_W-1:COL_W] == cur_idx_q);
`endif
        end
    end

    logic [7:0] ascii;

    text_char_buf #(
        .NUM_CHARS(NUM_CHARS)
    ) u_char_buf (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_start(frame_start),
        .wr         (wr),
        .rd_idx     (s1_idx),
        .rd_ascii   (ascii)
    );

    // Stage 2: fetch the character code and form ascii*GLYPH_H + row.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sprite_on   <= 1'b0;
            sprite_addr <= '0;
            glyph_col   <= '0;
        end else begin
            sprite_on   <= s1_hit;
            sprite_addr <= s1_hit ? {ascii, s1_row} : '0;
            glyph_col   <= s1_col;
        end
    end

`ifdef TEXT_CURSOR_EN
    // Stage 2 cursor flag, aligned with the address it qualifies.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) glyph_invert <= 1'b0;
        else       glyph_invert <= s1_inv;
    end
`else
    assign glyph_invert = 1'b0;
`endif

endmodule

// File: tb/tb_text_addr_gen.sv
// Directed bench for text_addr_gen with hand-computed expected values.
// Cursor checks are compiled only when TEXT_CURSOR_EN is defined.
module tb_text_addr_gen;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_start = 1'b0;
    logic [10:0] origin_x = '0;
    logic [10:0] origin_y = '0;
    logic [9:0]  DrawX = '0;
    logic [9:0]  DrawY = '0;
    logic        sprite_on;
    logic [11:0] sprite_addr;
    logic [2:0]  glyph_col;
    logic        glyph_invert;
`ifdef TEXT_CURSOR_EN
    logic        cursor_en = 1'b0;
    logic [3:0]  cursor_idx = '0;
`endif

    int total = 0;
    int bad = 0;

    text_addr_gen_if #(.IDX_W(4)) wr_bus ();

    text_addr_gen dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_start (frame_start),
        .origin_x    (origin_x),
        .origin_y    (origin_y),
        .wr          (wr_bus),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
`ifdef TEXT_CURSOR_EN
        .cursor_en   (cursor_en),
        .cursor_idx  (cursor_idx),
`endif
        .sprite_on   (sprite_on),
        .sprite_addr (sprite_addr),
        .glyph_col   (glyph_col),
        .glyph_invert(glyph_invert)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic pulse_frame(input int x, input int y);
        origin_x = 11'(x);
        origin_y = 11'(y);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic write_char(input int idx, input int code);
        wr_bus.wr_valid = 1'b1;
        wr_bus.wr_index = 4'(idx);
        wr_bus.wr_ascii = 8'(code);
        tick();
        wr_bus.wr_valid = 1'b0;
    endtask

    // Present a pixel and check the outputs two cycles later.
    task automatic pix(input string tag, input int x, input int y,
                       input int on, input int addr, input int col, input int inv);
        DrawX = 10'(x);
        DrawY = 10'(y);
        tick();
        tick();
        check({tag, ".on"},   32'(sprite_on),    32'(on));
        check({tag, ".addr"}, 32'(sprite_addr),  32'(addr));
        check({tag, ".col"},  32'(glyph_col),    32'(col));
        check({tag, ".inv"},  32'(glyph_invert), 32'(inv));
    endtask

    initial begin
        wr_bus.wr_valid = 1'b0;
        wr_bus.wr_index = '0;
        wr_bus.wr_ascii = '0;

        // Reset state
        repeat (3) tick();
        Reset = 1'b0;
        tick();
        check("rst.on", 32'(sprite_on), 0);
        check("rst.addr", 32'(sprite_addr), 0);
        check("rst.ready", 32'(wr_bus.wr_ready), 1);

        // Blank string at origin (100,50): every hit is 0x200 + dy
        pulse_frame(100, 50);
        pix("blank.tl",    100, 50, 1, 'h200, 0, 0);
        pix("blank.mid",   107, 65, 1, 'h20F, 7, 0);
        pix("blank.last",  227, 50, 1, 'h200, 7, 0);
        pix("blank.right", 228, 50, 0, 0, 0, 0);
        pix("blank.left",   99, 50, 0, 0, 0, 0);
        pix("blank.below", 100, 66, 0, 0, 0, 0);
        pix("blank.above", 100, 49, 0, 0, 0, 0);

        // 'A' at index 3: invisible until the swap, then 0x415
        write_char(3, 'h41);
        pix("a.preswap", 124, 55, 1, 'h205, 0, 0);
        pulse_frame(100, 50);
        pix("a.swap", 124, 55, 1, 'h415, 0, 0);

        // Write held across the frame_start cycle
        frame_start = 1'b1;
        wr_bus.wr_valid = 1'b1;
        wr_bus.wr_index = 4'd5;
        wr_bus.wr_ascii = 8'h42;
        #1;
        check("fs.ready_low", 32'(wr_bus.wr_ready), 0);
        tick();
        frame_start = 1'b0;
        #1;
        check("fs.ready_high", 32'(wr_bus.wr_ready), 1);
        tick();
        wr_bus.wr_valid = 1'b0;
        pix("fs.not_yet", 140, 50, 1, 'h200, 0, 0);
        pulse_frame(100, 50);
        pix("fs.visible", 140, 50, 1, 'h420, 0, 0);
        pix("fs.keep_a",  124, 50, 1, 'h410, 0, 0);

        // Origin near the right edge: only char 0 columns 1020..1023 hit
        pulse_frame(1020, 50);
        pix("clip.first", 1020, 50, 1, 'h200, 0, 0);
        pix("clip.last",  1023, 51, 1, 'h201, 3, 0);
        pix("clip.x0",       0, 50, 0, 0, 0, 0);
        pix("clip.x3",       3, 50, 0, 0, 0, 0);
        pix("clip.x1019", 1019, 50, 0, 0, 0, 0);

        // Reset mid-scanline with a hit in the output register
        pulse_frame(100, 50);
        DrawX = 10'd124;
        DrawY = 10'd55;
        tick();
        tick();
        check("mid.pre_on", 32'(sprite_addr), 'h415);
        #2;
        Reset = 1'b1;
        #1;
        check("mid.on", 32'(sprite_on), 0);
        check("mid.addr", 32'(sprite_addr), 0);
        check("mid.col", 32'(glyph_col), 0);
        tick();
        Reset = 1'b0;
        tick();
        check("mid.ready", 32'(wr_bus.wr_ready), 1);
        pulse_frame(100, 50);
        pix("mid.space", 124, 55, 1, 'h205, 0, 0);

`ifdef TEXT_CURSOR_EN
        // Cursor on char 2: phase flips every 30 frame_start pulses from reset
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        cursor_en = 1'b1;
        cursor_idx = 4'd2;
        repeat (29) pulse_frame(100, 50);
        pix("cur.phase0", 116, 50, 1, 'h200, 0, 0);
        pulse_frame(100, 50);
        pix("cur.on",     116, 50, 1, 'h200, 0, 1);
        pix("cur.on_c7",  123, 52, 1, 'h202, 7, 1);
        pix("cur.char1",  108, 50, 1, 'h200, 0, 0);
        pix("cur.char3",  124, 50, 1, 'h200, 0, 0);
        pix("cur.miss",    99, 50, 0, 0, 0, 0);
        repeat (30) pulse_frame(100, 50);
        pix("cur.off",    116, 50, 1, 'h200, 0, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
